universal_shift_reg_burst: RTL and testbench

- Parametrised successor to the 4-bit bidirectional shift register.
- WIDTH-bit universal register supporting hold, shift, rotate, arithmetic shift, parallel load and clear.
- Adds an autonomous burst engine: a single start pulse performs `len` consecutive shifts in a chosen direction, with busy/done handshake.
- Used as a serialiser/deserialiser and barrel-style pre-shifter in datapath exercises.

---
 rtl/universal_shift_reg_burst.sv | 134 +++++++++++++
 tb/tb_universal_shift_reg_burst.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/universal_shift_reg_burst.sv
// ---------------------------------------------------------------------------
// universal_shift_reg_burst
//
// WIDTH-bit universal shift register with an autonomous burst shifter.
// In IDLE a 3-bit mode selects one single-cycle operation: hold, shift
// right/left, load, rotate right/left, arithmetic shift right or clear.
// A start pulse in IDLE launches a burst of `len` shifts in direction `dir`.
// busy is high during the burst, and done pulses once when the burst completes.
//
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   en     : clock enable; low freezes register, FSM, counter and done
//   mode   : single-cycle operation select (IDLE only)
//   Dr, Dl : serial inputs for right (enters MSB) / left (enters LSB) shifts
//   d      : parallel load data
//   start  : burst request (IDLE only); dir/len captured with it
//   dir    : burst direction, 0 = right, 1 = left
//   len    : burst shift count (0 gives an immediate done, no shift)
//   q      : register contents; q_bar its inverse
//   sout_r : q[0]; sout_l : q[WIDTH-1]
//   busy   : high while bursting; done : one-cycle completion pulse
// ---------------------------------------------------------------------------
module universal_shift_reg_burst #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             Dr,
    input  logic             Dl,
    input  logic [WIDTH-1:0] d,
    input  logic             start,
    input  logic             dir,
    input  logic [LEN_W-1:0] len,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             done
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   q_reg, q_next;
    logic [LEN_W-1:0]   cnt_reg, cnt_next;
    logic               dir_reg, dir_next;
    logic               done_reg, done_next;

    // Next-state and datapath logic
    always_comb begin
        state_next = state_reg;
        q_next     = q_reg;
        cnt_next   = cnt_reg;
        dir_next   = dir_reg;
        done_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    // start takes priority over mode; no mode operation here
                    if (len != '0) begin
                        state_next = BURST;
                        cnt_next   = len;
                        dir_next   = dir;
                    end else begin
                        done_next = 1'b1;
                    end
                end else begin
                    case (mode)
                        3'b000: q_next = q_reg;
                        3'b001: q_next = {Dr, q_reg[WIDTH-1:1]};
                        3'b010: q_next = {q_reg[WIDTH-2:0], Dl};
                        3'b011: q_next = d;
                        3'b100: q_next = {q_reg[0], q_reg[WIDTH-1:1]};
                        3'b101: q_next = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
                        3'b110: q_next = {q_reg[WIDTH-1], q_reg[WIDTH-1:1]};
                        default: q_next = '0;
                    endcase
                end
            end
            BURST: begin
                // Shift using the live serial input for the captured direction
                if (dir_reg)
                    q_next = {q_reg[WIDTH-2:0], Dl};
                else
                    q_next = {Dr, q_reg[WIDTH-1:1]};
                cnt_next = cnt_reg - LEN_W'(1);
                if (cnt_reg == LEN_W'(1)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register; with en low everything, including done, holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            q_reg     <= '0;
            cnt_reg   <= '0;
            dir_reg   <= 1'b0;
            done_reg  <= 1'b0;
        end else if (en) begin
            state_reg <= state_next;
            q_reg     <= q_next;
            cnt_reg   <= cnt_next;
            dir_reg   <= dir_next;
            done_reg  <= done_next;
        end
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_qbar
            assign q_bar[gi] = ~q_reg[gi];
        end
    endgenerate

    assign q      = q_reg;
    assign sout_r = q_reg[0];
    assign sout_l = q_reg[WIDTH-1];
    assign busy   = (state_reg == BURST);
    assign done   = done_reg;

endmodule

// File: tb/tb_universal_shift_reg_burst.sv
// ---------------------------------------------------------------------------
// Testbench for universal_shift_reg_burst (WIDTH=8, LEN_W=4).
// A behavioural model (integer arithmetic plus a remaining-shifts count) is
// compared against the DUT on every falling edge. Directed steps also check
// hand-computed literal values.
// ---------------------------------------------------------------------------
module tb_universal_shift_reg_burst;

    localparam int WIDTH = 8;
    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b1;
    logic [2:0]       mode = 3'b000;
    logic             Dr = 1'b0;
    logic             Dl = 1'b0;
    logic [WIDTH-1:0] d = '0;
    logic             start = 1'b0;
    logic             dir = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic [WIDTH-1:0] q, q_bar;
    logic             sout_r, sout_l, busy, done;

    int pass_cnt = 0;
    int total_cnt = 0;

    universal_shift_reg_burst #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .Dr(Dr), .Dl(Dl),
        .d(d), .start(start), .dir(dir), .len(len), .q(q), .q_bar(q_bar),
        .sout_r(sout_r), .sout_l(sout_l), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int m_q = 0;
    int m_rem = 0;
    bit m_busy = 1'b0;
    bit m_done = 1'b0;
    bit m_dir = 1'b0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_q = 0; m_rem = 0; m_busy = 0; m_done = 0;
            end else if (en) begin
                if (m_busy) begin
                    if (m_dir) m_q = ((m_q * 2) % 256) + int'(Dl);
                    else       m_q = (m_q / 2) + 128 * int'(Dr);
                    m_rem  = m_rem - 1;
                    m_done = (m_rem == 0);
                    if (m_rem == 0) m_busy = 0;
                end else begin
                    m_done = 0;
                    if (start) begin
                        if (len == 0) m_done = 1;
                        else begin
                            m_busy = 1; m_rem = int'(len); m_dir = dir;
                        end
                    end else begin
                        case (mode)
                            3'd1: m_q = (m_q / 2) + 128 * int'(Dr);
                            3'd2: m_q = ((m_q * 2) % 256) + int'(Dl);
                            3'd3: m_q = int'(d);
                            3'd4: m_q = (m_q / 2) + 128 * (m_q % 2);
                            3'd5: m_q = ((m_q * 2) % 256) + (m_q / 128);
                            3'd6: m_q = (m_q / 2) + (m_q / 128) * 128;
                            3'd7: m_q = 0;
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [WIDTH-1:0] eq;
        eq = WIDTH'(m_q);
        total_cnt++;
        if (q === eq && q_bar === ~eq && sout_r === eq[0] && sout_l === eq[WIDTH-1]
            && busy === m_busy && done === m_done)
            pass_cnt++;
        else
            $display("FAIL model_cmp t=%0t: q=%h qb=%h sr=%b sl=%b busy=%b done=%b, required q=%h busy=%b done=%b",
                     $time, q, q_bar, sout_r, sout_l, busy, done, eq, m_busy, m_done);
    end

    // ---------------- directed checks ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
            $display("check %s: %h ok", name, act);
        end else begin
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // one enabled clock: inputs already set; land 1 time unit after the falling edge
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    initial begin
        // reset
        cyc(); cyc();
        chk("rst_q", 32'(q), 32'h00);
        chk("rst_qbar", 32'(q_bar), 32'hFF);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        rst_n = 1'b1;

        // load / rotate
        mode = 3'b011; d = 8'hA5; cyc();
        chk("load_q", 32'(q), 32'hA5);
        chk("load_qbar", 32'(q_bar), 32'h5A);
        mode = 3'b100; cyc(); chk("rotr", 32'(q), 32'hD2);
        mode = 3'b101; cyc(); chk("rotl", 32'(q), 32'hA5);

        // serial shifts
        mode = 3'b111; cyc(); chk("clear0", 32'(q), 32'h00);
        mode = 3'b001;
        Dr = 1; cyc(); Dr = 0; cyc(); Dr = 1; cyc(); Dr = 0; cyc();
        chk("shr_serial", 32'(q), 32'h50);
        mode = 3'b010;
        Dl = 1; cyc(); Dl = 1; cyc(); Dl = 0; cyc(); Dl = 1; cyc();
        chk("shl_serial", 32'(q), 32'h0D);
        chk("sout_r", 32'(sout_r), 32'h1);

        // arithmetic shift right
        mode = 3'b011; d = 8'h80; cyc();
        mode = 3'b110; cyc(); cyc(); cyc();
        chk("asr3", 32'(q), 32'hF0);
        chk("sout_l", 32'(sout_l), 32'h1);
        mode = 3'b111; cyc(); chk("clear", 32'(q), 32'h00);

        // burst right, len=3
        mode = 3'b011; d = 8'h81; cyc();
        mode = 3'b000; start = 1; dir = 0; len = 3; Dr = 0; cyc();
        chk("b1_busy0", 32'(busy), 32'h1);
        chk("b1_q0", 32'(q), 32'h81);
        start = 0; cyc(); chk("b1_q1", 32'(q), 32'h40);
        cyc(); chk("b1_q2", 32'(q), 32'h20);
        chk("b1_done_early", 32'(done), 32'h0);
        cyc();
        chk("b1_q3", 32'(q), 32'h10);
        chk("b1_done", 32'(done), 32'h1);
        chk("b1_busy_end", 32'(busy), 32'h0);
        cyc(); chk("b1_done_clr", 32'(done), 32'h0);

        // burst left, len=5, with a 2-cycle enable gap and a start while busy
        start = 1; dir = 1; len = 5; Dl = 1; cyc();
        chk("b2_busy", 32'(busy), 32'h1);
        mode = 3'b011; d = 8'hFF; dir = 0; len = 1; // ignored while busy
        cyc(); chk("b2_q1", 32'(q), 32'h21);
        en = 0; cyc(); cyc();
        chk("b2_freeze_q", 32'(q), 32'h21);
        chk("b2_freeze_busy", 32'(busy), 32'h1);
        en = 1; Dl = 0; cyc(); chk("b2_q2", 32'(q), 32'h42);
        Dl = 1; cyc(); chk("b2_q3", 32'(q), 32'h85);
        cyc(); chk("b2_q4", 32'(q), 32'h0B);
        chk("b2_done_early", 32'(done), 32'h0);
        start = 0; mode = 3'b000; Dl = 0; cyc();
        chk("b2_q5", 32'(q), 32'h16);
        chk("b2_done", 32'(done), 32'h1);
        cyc();
        chk("b2_no_requeue", 32'(busy), 32'h0);
        chk("b2_done_clr", 32'(done), 32'h0);

        // burst len=6 aborted by reset after 2 shifts
        start = 1; dir = 0; len = 6; Dr = 1; cyc();
        start = 0; cyc(); chk("b3_q1", 32'(q), 32'h8B);
        cyc(); chk("b3_q2", 32'(q), 32'hC5);
        rst_n = 0; #1;
        chk("b3_rst_q", 32'(q), 32'h00);
        chk("b3_rst_busy", 32'(busy), 32'h0);
        cyc(); chk("b3_rst_done", 32'(done), 32'h0);
        rst_n = 1;

        // len=0: immediate done, q unchanged
        mode = 3'b011; d = 8'h3C; cyc();
        mode = 3'b000; start = 1; len = 0; cyc();
        chk("len0_done", 32'(done), 32'h1);
        chk("len0_q", 32'(q), 32'h3C);
        chk("len0_busy", 32'(busy), 32'h0);
        start = 0; cyc(); chk("len0_done_clr", 32'(done), 32'h0);

        // back-to-back: new start accepted while done is high
        start = 1; dir = 1; len = 1; Dl = 1; cyc();
        start = 0; cyc();
        chk("bb_q1", 32'(q), 32'h79);
        chk("bb_done1", 32'(done), 32'h1);
        start = 1; dir = 0; len = 2; Dr = 0; cyc();
        chk("bb_busy2", 32'(busy), 32'h1);
        chk("bb_done_clr", 32'(done), 32'h0);
        start = 0; cyc(); chk("bb_q2", 32'(q), 32'h3C);
        cyc();
        chk("bb_q3", 32'(q), 32'h1E);
        chk("bb_done2", 32'(done), 32'h1);
        cyc();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
